adder_tree_sched: RTL and testbench
===================================

ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 18, operands per adder-tree beat.
REQ-002 SHALL have parameter IN_WIDTH, default 8, signed operand width.
REQ-003 SHALL have parameter PASS_NUM, default 4, tree beats accumulated per result (>=1).
REQ-004 SHALL have parameter OUT_WIDTH, default 12, signed result width on m_data.
REQ-005 SHALL derive LATENCY = $clog2(INPUT_NUM)+1, TREE_W = IN_WIDTH+$clog2(INPUT_NUM), ACC_W = TREE_W+$clog2(PASS_NUM), all as localparams.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port s_valid, input, 1, upstream beat valid.
REQ-009 SHALL have port s_ready, output, 1, beat accepted when s_valid && s_ready at a rising edge.
REQ-010 SHALL have port s_data, input, INPUT_NUM*IN_WIDTH, packed signed operands, operand j at bits [(j+1)*IN_WIDTH-1 -: IN_WIDTH].
REQ-011 SHALL have port tree_en, output, 1, drives adder_tree add_en.
REQ-012 SHALL have port tree_din, output, INPUT_NUM*IN_WIDTH, drives adder_tree din; equals s_data combinationally.
REQ-013 SHALL have port tree_dout, input, TREE_W, signed adder_tree dout.
REQ-014 SHALL have port m_valid, output, 1, result valid.
REQ-015 SHALL have port m_ready, input, 1, result consumed when m_valid && m_ready at a rising edge.
REQ-016 SHALL have port m_data, output, OUT_WIDTH, signed accumulated result.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-019 SHALL assert s_ready in IDLE, and in FEED while accepted-beat count < PASS_NUM; deassert in DRAIN and DONE.
REQ-020 SHALL move IDLE->FEED on a handshake, clearing accumulator and result count and counting that beat as 1 (PASS_NUM=1: IDLE->DRAIN directly).
REQ-021 SHALL move FEED->DRAIN on the handshake that makes accepted count equal PASS_NUM.
REQ-022 SHALL drive tree_en = (state is FEED or DRAIN) || (s_valid && s_ready); non-handshake FEED cycles insert bubbles.
REQ-023 SHALL track beats with a LATENCY-deep valid shift register, shifting only when tree_en=1, bit 0 loaded with the handshake.
REQ-024 SHALL add sign-extended tree_dout into the ACC_W accumulator on each edge where valid-register tail is 1, incrementing result count.
REQ-025 SHALL move DRAIN->DONE on the edge that accumulates result PASS_NUM.
REQ-026 SHALL hold m_valid=1 and m_data stable throughout DONE; m_valid=0 in all other states.
REQ-027 SHALL move DONE->IDLE on m_valid && m_ready; s_valid in that cycle is not accepted.
REQ-028 SHALL, for back-to-back beats, raise m_valid after edge number PASS_NUM-1+LATENCY counting the first handshake edge as 0.
REQ-029 SHALL ignore s_valid deassertion mid-FEED (wait indefinitely, bubbles accrue no sum).

Reset
REQ-030 SHALL on rst_n=0, at any time including mid-FEED/DRAIN, immediately force IDLE, s_ready=1, m_valid=0, m_data=0, busy=0, tree_en per REQ-022, valid register, counters, accumulator=0.

Configuration
REQ-031 SHALL, with ADDER_TREE_SCHED_SAT_EN defined, clamp accumulator to signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] on m_data.
REQ-032 SHALL, without ADDER_TREE_SCHED_SAT_EN, drive m_data with accumulator bits [OUT_WIDTH-1:0] (two's-complement wrap).

Verification
REQ-033 SHALL cover: 4 back-to-back beats, all operands 1 -> m_data=72, m_valid after edge 9, held until m_ready.
REQ-034 SHALL cover: 4 beats all 127 -> m_data=2047 with SAT_EN, 952 without.
REQ-035 SHALL cover: 4 beats all -128 -> m_data=-2048 with SAT_EN, -1024 without.
REQ-036 SHALL cover: beats spaced by 2 idle cycles, operand j = j-9 -> m_data=-36 (4 x -9), s_ready low in DRAIN/DONE.
REQ-037 SHALL cover: m_ready low 5 cycles in DONE -> m_data stable, s_ready=0, no beat lost; next result correct.
REQ-038 SHALL cover: rst_n pulsed low during DRAIN -> outputs at reset values immediately; next full run yields correct sum.

Source files
------------

// File: rtl/adder_tree_sched.sv
// Scheduler around an external pipelined adder tree: feeds PASS_NUM beats, accumulates
// the tree outputs and presents one result. Optional clamp: ADDER_TREE_SCHED_SAT_EN.
module adder_tree_sched #(
  parameter int INPUT_NUM = 18,
  parameter int IN_WIDTH  = 8,
  parameter int PASS_NUM  = 4,
  parameter int OUT_WIDTH = 12
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [INPUT_NUM*IN_WIDTH-1:0]                s_data,
  output logic                                         tree_en,
  output logic [INPUT_NUM*IN_WIDTH-1:0]                tree_din,
  input  logic signed [IN_WIDTH+$clog2(INPUT_NUM)-1:0] tree_dout,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic signed [OUT_WIDTH-1:0]                  m_data,
  output logic                                         busy
);

  localparam int LATENCY = $clog2(INPUT_NUM) + 1;
  localparam int TREE_W  = IN_WIDTH + $clog2(INPUT_NUM);
  localparam int ACC_W   = TREE_W + $clog2(PASS_NUM);
  localparam int CNT_W   = $clog2(PASS_NUM + 1);
  localparam logic [CNT_W-1:0] PASS_CNT = CNT_W'(PASS_NUM);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]        res_cnt_q, res_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LATENCY-1:0]      vld_q, vld_d, vld_shift;
  logic                    hs;
  logic                    acc_fire;

  assign s_ready  = (state_q == IDLE) || ((state_q == FEED) && (beat_cnt_q < PASS_CNT));
  assign hs       = s_valid && s_ready;
  // The tree keeps advancing through bubbles in FEED/DRAIN so in-flight beats drain out.
  assign tree_en  = (state_q == FEED) || (state_q == DRAIN) || hs;
  assign tree_din = s_data;
  assign acc_fire = vld_q[LATENCY-1] && tree_en;
  assign m_valid  = (state_q == DONE);
  assign busy     = (state_q != IDLE);

  generate
    if (LATENCY == 1) begin : g_vld_single
      assign vld_shift = hs;
    end else begin : g_vld_multi
      assign vld_shift = {vld_q[LATENCY-2:0], hs};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    res_cnt_d  = res_cnt_q;
    acc_d      = acc_q;
    vld_d      = tree_en ? vld_shift : vld_q;

    if (acc_fire) begin
      acc_d     = acc_q + ACC_W'(tree_dout);
      res_cnt_d = res_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (hs) begin
          beat_cnt_d = CNT_W'(1);
          res_cnt_d  = '0;
          acc_d      = '0;
          state_d    = (PASS_NUM == 1) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q + CNT_W'(1) == PASS_CNT) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (acc_fire && (res_cnt_q + CNT_W'(1) == PASS_CNT)) state_d = DONE;
      end
      DONE: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      res_cnt_q  <= '0;
      acc_q      <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      res_cnt_q  <= res_cnt_d;
      acc_q      <= acc_d;
      vld_q      <= vld_d;
    end
  end

`ifdef ADDER_TREE_SCHED_SAT_EN
  localparam int MW = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
  localparam logic signed [MW-1:0] SAT_MAX =
    $signed({{(MW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [MW-1:0] SAT_MIN =
    $signed({{(MW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  logic signed [MW-1:0] acc_ext;
  assign acc_ext = MW'(acc_q);

  always_comb begin
    if (acc_ext > SAT_MAX)      m_data = OUT_WIDTH'(SAT_MAX);
    else if (acc_ext < SAT_MIN) m_data = OUT_WIDTH'(SAT_MIN);
    else                        m_data = OUT_WIDTH'(acc_ext);
  end
`else
  assign m_data = OUT_WIDTH'(acc_q);
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Randomized self-checking bench for adder_tree_sched with a behavioural adder-tree
// pipeline and a transaction-level sum model (honours ADDER_TREE_SCHED_SAT_EN).
module tb_adder_tree_sched;
  localparam int INPUT_NUM = 18;
  localparam int IN_WIDTH  = 8;
  localparam int PASS_NUM  = 4;
  localparam int OUT_WIDTH = 12;
  localparam int LATENCY   = $clog2(INPUT_NUM) + 1;
  localparam int TREE_W    = IN_WIDTH + $clog2(INPUT_NUM);
  localparam int DW        = INPUT_NUM * IN_WIDTH;

  logic                        clk;
  logic                        rst_n;
  logic                        s_valid;
  logic                        s_ready;
  logic [DW-1:0]               s_data;
  logic                        tree_en;
  logic [DW-1:0]               tree_din;
  logic signed [TREE_W-1:0]    tree_dout;
  logic                        m_valid;
  logic                        m_ready;
  logic signed [OUT_WIDTH-1:0] m_data;
  logic                        busy;

  int checks   = 0;
  int failures = 0;
  int results  = 0;

  logic [DW-1:0]            beats [PASS_NUM];
  logic signed [TREE_W-1:0] pipe  [LATENCY];

  adder_tree_sched #(
    .INPUT_NUM(INPUT_NUM), .IN_WIDTH(IN_WIDTH), .PASS_NUM(PASS_NUM), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tree_en(tree_en), .tree_din(tree_din), .tree_dout(tree_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int beat_sum(input logic [DW-1:0] v);
    int s = 0;
    for (int j = 0; j < INPUT_NUM; j++) s += int'($signed(v[(j+1)*IN_WIDTH-1 -: IN_WIDTH]));
    return s;
  endfunction

  // Environment: a LATENCY-stage adder tree that advances only when enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
    end else if (tree_en) begin
      for (int k = LATENCY - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= TREE_W'(beat_sum(tree_din));
    end
  end
  assign tree_dout = pipe[LATENCY-1];

  function automatic int ref_total();
    int t = 0;
    for (int i = 0; i < PASS_NUM; i++) t += beat_sum(beats[i]);
    return t;
  endfunction

  function automatic int expect_out(input int total);
    logic signed [OUT_WIDTH-1:0] w;
`ifdef ADDER_TREE_SCHED_SAT_EN
    int hi = (1 << (OUT_WIDTH - 1)) - 1;
    int lo = -(1 << (OUT_WIDTH - 1));
    if (total > hi) return hi;
    if (total < lo) return lo;
    return total;
`else
    w = OUT_WIDTH'(total);
    return int'(w);
`endif
  endfunction

  task automatic fill_const(input int val);
    for (int i = 0; i < PASS_NUM; i++)
      for (int j = 0; j < INPUT_NUM; j++) beats[i][(j+1)*IN_WIDTH-1 -: IN_WIDTH] = IN_WIDTH'(val);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < PASS_NUM; i++)
      for (int j = 0; j < INPUT_NUM; j++) beats[i][(j+1)*IN_WIDTH-1 -: IN_WIDTH] = IN_WIDTH'(j - 9);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < PASS_NUM; i++)
      for (int j = 0; j < INPUT_NUM; j++)
        beats[i][(j+1)*IN_WIDTH-1 -: IN_WIDTH] = IN_WIDTH'($urandom_range(0, 255));
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic feed(input int gap);
    for (int i = 0; i < PASS_NUM; i++) begin
      send_beat(beats[i]);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_result(input bit chk_ready, output int n);
    n = 0;
    while (!m_valid && n < 200) begin
      if (chk_ready && s_ready !== 1'b0) begin
        checks++; failures++;
        $display("FAIL drain_s_ready: s_ready=%0b required 0", s_ready);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL result_timeout: m_valid=%0b required 1", m_valid);
    end
  endtask

  task automatic check_result(input string name);
    int exp_v = expect_out(ref_total());
    checks++;
    results++;
    $display("result %0d (%s): m_data=%0d expected=%0d", results, name, m_data, exp_v);
    if (int'(m_data) !== exp_v) begin
      failures++;
      $display("FAIL %s_data: m_data=%0d required %0d", name, m_data, exp_v);
    end
  endtask

  task automatic consume(input int hold, input string name);
    logic signed [OUT_WIDTH-1:0] held = m_data;
    m_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_hold: m_valid=%0b m_data=%0d s_ready=%0b busy=%0b required 1 %0d 0 1",
                 name, m_valid, m_data, s_ready, busy, held);
      end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: m_valid=%0b busy=%0b required 0 0", name, m_valid, busy);
    end
  endtask

  task automatic run_b2b(input string name);
    int edge_idx;
    s_valid = 1'b1;
    for (int i = 0; i < PASS_NUM; i++) begin
      s_data = beats[i];
      if (s_ready !== 1'b1) begin
        checks++; failures++;
        $display("FAIL %s_b2b_ready: s_ready=%0b required 1 at beat %0d", name, s_ready, i);
      end
      @(posedge clk); #1;
    end
    s_valid  = 1'b0;
    edge_idx = PASS_NUM - 1;
    while (!m_valid && edge_idx < 200) begin
      @(posedge clk); #1;
      edge_idx++;
    end
    checks++;
    if (edge_idx !== PASS_NUM - 1 + LATENCY || m_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: m_valid after edge %0d required edge %0d",
               name, edge_idx, PASS_NUM - 1 + LATENCY);
    end
    check_result(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0 || tree_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: s_ready=%0b m_valid=%0b m_data=%0d busy=%0b tree_en=%0b required 1 0 0 0 0",
               s_ready, m_valid, m_data, busy, tree_en);
    end
    s_valid = 1'b1; #1;
    checks++;
    if (tree_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_tree_en: tree_en=%0b required 1", tree_en);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ones();
    fill_const(1);
    run_b2b("ones");
    consume(3, "ones");
  endtask

  task automatic test_extremes();
    fill_const(127);
    run_b2b("max");
    consume(0, "max");
    fill_const(-128);
    run_b2b("min");
    consume(1, "min");
  endtask

  task automatic test_spaced();
    int n;
    fill_ramp();
    feed(2);
    wait_result(1'b1, n);
    check_result("spaced");
    consume(2, "spaced");
  endtask

  task automatic test_back_to_back();
    int n;
    fill_rand();
    feed(0);
    wait_result(1'b0, n);
    check_result("bp_first");
    fill_rand();
    s_valid = 1'b1;
    s_data  = beats[0];
    consume(5, "bp");
    feed(0);
    wait_result(1'b0, n);
    check_result("bp_second");
    consume(0, "bp_second");
  endtask

  task automatic test_reset_mid();
    int n;
    fill_const(5);
    feed(0);
    for (int k = 0; k < LATENCY - 2; k++) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_drain_state: busy=%0b m_valid=%0b required 1 0", busy, m_valid);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0 || tree_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: s_ready=%0b m_valid=%0b m_data=%0d busy=%0b tree_en=%0b required 1 0 0 0 0",
               s_ready, m_valid, m_data, busy, tree_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_rand();
    feed(0);
    wait_result(1'b0, n);
    check_result("after_reset");
    consume(0, "after_reset");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 12; r++) begin
      fill_rand();
      feed(int'($urandom_range(0, 2)));
      wait_result(1'b0, n);
      check_result("random");
      consume(int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_extremes();
    test_spaced();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
